sr_latch: RTL and testbench
===========================

// Module: sr_latch
// PURPOSE
//   Clocked emulation of a cross-coupled NAND SR latch with active-low set and
//   reset inputs and complementary outputs Q / Qn. Inputs are sampled on the
//   rising clock edge, so the storage element is a synchronous FSM rather than
//   a combinational loop. The block serves as a small state-holding element for
//   switch and button debounce logic and for lab-style control paths.
// PARAMETERS
//   SYNC_STAGES   0  number of flop stages on S and R before the state logic;
//                    0 = sampled directly; each stage adds one cycle of latency
//   RELEASE_STATE 0  Q value taken when leaving INVALID with S=R=1 (0 or 1)
// PORTS
//   clk      in   1  system clock; all state changes occur on its rising edge
//   rst      in   1  reset, synchronous, active-high
//   S        in   1  set, active-low (0 = set request)
//   R        in   1  reset, active-low (0 = reset request)
//   Q        out  1  latch output, registered
//   Qn       out  1  complementary output, registered (not ~Q while INVALID)
//   invalid  out  1  high while S and R are asserted together (state INVALID)
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high: on a clk edge with
//     rst=1, state=RESET, Q=0, Qn=1, invalid=0, and all sync stages load 1
//     (deasserted). rst takes priority over S and R.
//   - States: RESET (Q=0,Qn=1), SET (Q=1,Qn=0), INVALID (Q=1,Qn=1,invalid=1).
//     Outputs are decoded from registered state, with no combinational path
//     from the inputs to the outputs.
//   - Let s,r be the inputs after SYNC_STAGES flops. Next state, by priority:
//       s=0,r=0 -> INVALID (NAND both-asserted condition)
//       s=0,r=1 -> SET
//       s=1,r=0 -> RESET
//       s=1,r=1 -> hold current state; from INVALID go to SET if
//                  RELEASE_STATE=1, else RESET
//   - Latency: an input change is visible on Q/Qn at clk edge 1+SYNC_STAGES
//     after the change. With SYNC_STAGES=0, a change is seen on the next edge.
//   - Q/Qn never glitch between edges. Q and Qn are never both 0.
//   - Input pulses shorter than one clock period and falling between edges may
//     be missed. This is permitted and must be documented at the integration
//     level.
//   - S=R=1 held indefinitely: state holds, with no oscillation and no drift.
//   - rst asserted mid-INVALID or mid-SET: the state returns to RESET on that
//     edge regardless of S/R. After rst falls, the current S/R are evaluated on
//     the next edge.
//   - Direct transitions SET<->RESET, SET->INVALID and RESET->INVALID all take
//     one state-update edge.
//   - X on S or R after reset is out of scope; the bench drives known levels.
// TESTING (clk 10 ns, SYNC_STAGES=0, RELEASE_STATE=0, stimulus every 100 ns)
//   1. rst=1 for 2 edges, S=R=1 -> Q=0, Qn=1, invalid=0; holds after rst drops.
//   2. S=0 for 100 ns, then S=1 -> Q=1/Qn=0 one edge after S falls; Q=1 is
//      retained after S returns to 1.
//   3. R=0 for 100 ns, then R=1 -> Q=0/Qn=1 one edge after R falls; retained.
//   4. S=R=0 -> Q=1, Qn=1, invalid=1. Then S=R=1 -> Q=0, Qn=1, invalid=0.
//      Repeat S=R=0 -> INVALID again.
//   5. While in SET, assert rst=1 for 1 edge with S=0 -> Q=0 on that edge;
//      Q=1 again on the next edge after rst=0.
//   6. SYNC_STAGES=2: S pulse low -> Q rises exactly 3 edges after S falls;
//      random S/R stream checked against a reference model every cycle.

Source files
------------

// File: rtl/sr_latch.sv
// rtl/sr_latch.sv - clocked NAND SR latch emulation with optional input synchronizer
module sr_latch #(
    parameter int SYNC_STAGES   = 0,
    parameter bit RELEASE_STATE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic S,
    input  logic R,
    output logic Q,
    output logic Qn,
    output logic invalid
);

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_SET     = 2'd1,
        ST_INVALID = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_s;
    logic   w_r;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign w_s = S;
            assign w_r = R;
        end else begin : g_sync
            // Bit 0 is the first stage; the top bit feeds the state logic.
            logic [SYNC_STAGES-1:0] r_s_sync;
            logic [SYNC_STAGES-1:0] r_r_sync;

            // Shift S/R through the synchronizer; reset loads the deasserted level.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s_sync <= '1;
                    r_r_sync <= '1;
                end else begin
                    r_s_sync <= (r_s_sync << 1) | SYNC_STAGES'(S);
                    r_r_sync <= (r_r_sync << 1) | SYNC_STAGES'(R);
                end
            end

            assign w_s = r_s_sync[SYNC_STAGES-1];
            assign w_r = r_r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // State register; rst overrides any pending set/reset request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state by NAND-latch priority, outputs decoded from registered state only.
    always_comb begin
        w_state_next = r_state;
        Q            = 1'b0;
        Qn           = 1'b1;
        invalid      = 1'b0;

        if (!w_s && !w_r) begin
            w_state_next = ST_INVALID;
        end else if (!w_s) begin
            w_state_next = ST_SET;
        end else if (!w_r) begin
            w_state_next = ST_RESET;
        end else begin
            case (r_state)
                ST_INVALID: w_state_next = RELEASE_STATE ? ST_SET : ST_RESET;
                ST_SET:     w_state_next = ST_SET;
                default:    w_state_next = ST_RESET;
            endcase
        end

        case (r_state)
            ST_SET: begin
                Q  = 1'b1;
                Qn = 1'b0;
            end
            ST_INVALID: begin
                Q       = 1'b1;
                Qn      = 1'b1;
                invalid = 1'b1;
            end
            default: begin
                Q  = 1'b0;
                Qn = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sr_latch.sv
// tb/tb_sr_latch.sv - directed and model-checked bench for sr_latch
module tb_sr_latch;

    logic clk;
    logic rst;
    logic S;
    logic R;
    logic q0, qn0, inv0;
    logic q2, qn2, inv2;

    int n_checks;
    int n_pass;

    sr_latch #(.SYNC_STAGES(0), .RELEASE_STATE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .S(S), .R(R),
        .Q(q0), .Qn(qn0), .invalid(inv0)
    );

    sr_latch #(.SYNC_STAGES(2), .RELEASE_STATE(1'b1)) dut2 (
        .clk(clk), .rst(rst), .S(S), .R(R),
        .Q(q2), .Qn(qn2), .invalid(inv2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model state: 0 = RESET, 1 = SET, 2 = INVALID
    function automatic logic [1:0] model_next(input logic [1:0] cur, input logic s,
                                              input logic r, input bit rel);
        if (!s && !r)            return 2'd2;
        else if (!s)             return 2'd1;
        else if (!r)             return 2'd0;
        else if (cur == 2'd2)    return rel ? 2'd1 : 2'd0;
        else                     return cur;
    endfunction

    function automatic logic [2:0] model_out(input logic [1:0] st);
        case (st)
            2'd1:    return 3'b100;
            2'd2:    return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; S = 1'b1; R = 1'b1;
        tick(2);
        n_checks++; if (q0 !== 1'b0) $display("FAIL reset_q: got %b want 0", q0); else n_pass++;
        n_checks++; if (qn0 !== 1'b1) $display("FAIL reset_qn: got %b want 1", qn0); else n_pass++;
        n_checks++; if (inv0 !== 1'b0) $display("FAIL reset_invalid: got %b want 0", inv0); else n_pass++;
        rst = 1'b0;
        tick(10);
        n_checks++; if ({q0, qn0, inv0} !== 3'b010) $display("FAIL reset_hold: got %b want 010", {q0, qn0, inv0}); else n_pass++;
    endtask

    task automatic test_set();
        S = 1'b0;
        tick(1);
        n_checks++; if ({q0, qn0, inv0} !== 3'b100) $display("FAIL set_edge: got %b want 100", {q0, qn0, inv0}); else n_pass++;
        tick(9);
        S = 1'b1;
        tick(10);
        n_checks++; if ({q0, qn0, inv0} !== 3'b100) $display("FAIL set_retain: got %b want 100", {q0, qn0, inv0}); else n_pass++;
    endtask

    task automatic test_reset_req();
        R = 1'b0;
        tick(1);
        n_checks++; if ({q0, qn0, inv0} !== 3'b010) $display("FAIL rreq_edge: got %b want 010", {q0, qn0, inv0}); else n_pass++;
        tick(9);
        R = 1'b1;
        tick(10);
        n_checks++; if ({q0, qn0, inv0} !== 3'b010) $display("FAIL rreq_retain: got %b want 010", {q0, qn0, inv0}); else n_pass++;
    endtask

    task automatic test_invalid();
        S = 1'b0; R = 1'b0;
        tick(1);
        n_checks++; if ({q0, qn0, inv0} !== 3'b111) $display("FAIL inv_enter: got %b want 111", {q0, qn0, inv0}); else n_pass++;
        tick(9);
        n_checks++; if ({q0, qn0, inv0} !== 3'b111) $display("FAIL inv_hold: got %b want 111", {q0, qn0, inv0}); else n_pass++;
        S = 1'b1; R = 1'b1;
        tick(1);
        n_checks++; if ({q0, qn0, inv0} !== 3'b010) $display("FAIL inv_release: got %b want 010", {q0, qn0, inv0}); else n_pass++;
        tick(9);
        n_checks++; if ({q0, qn0, inv0} !== 3'b010) $display("FAIL inv_release_hold: got %b want 010", {q0, qn0, inv0}); else n_pass++;
        S = 1'b0; R = 1'b0;
        tick(1);
        n_checks++; if ({q0, qn0, inv0} !== 3'b111) $display("FAIL inv_reenter: got %b want 111", {q0, qn0, inv0}); else n_pass++;
        S = 1'b0; R = 1'b1;
        tick(1);
        n_checks++; if ({q0, qn0, inv0} !== 3'b100) $display("FAIL inv_to_set: got %b want 100", {q0, qn0, inv0}); else n_pass++;
        S = 1'b0; R = 1'b0;
        tick(1);
        n_checks++; if ({q0, qn0, inv0} !== 3'b111) $display("FAIL set_to_inv: got %b want 111", {q0, qn0, inv0}); else n_pass++;
        S = 1'b1; R = 1'b1;
        tick(9);
    endtask

    task automatic test_rst_override();
        S = 1'b0; R = 1'b1;
        tick(1);
        n_checks++; if ({q0, qn0, inv0} !== 3'b100) $display("FAIL ovr_set: got %b want 100", {q0, qn0, inv0}); else n_pass++;
        rst = 1'b1;
        tick(1);
        n_checks++; if ({q0, qn0, inv0} !== 3'b010) $display("FAIL ovr_rst_in_set: got %b want 010", {q0, qn0, inv0}); else n_pass++;
        rst = 1'b0;
        tick(1);
        n_checks++; if ({q0, qn0, inv0} !== 3'b100) $display("FAIL ovr_after_rst: got %b want 100", {q0, qn0, inv0}); else n_pass++;
        S = 1'b0; R = 1'b0;
        tick(1);
        n_checks++; if ({q0, qn0, inv0} !== 3'b111) $display("FAIL ovr_inv: got %b want 111", {q0, qn0, inv0}); else n_pass++;
        rst = 1'b1;
        tick(1);
        n_checks++; if ({q0, qn0, inv0} !== 3'b010) $display("FAIL ovr_rst_in_inv: got %b want 010", {q0, qn0, inv0}); else n_pass++;
        rst = 1'b0;
        tick(1);
        n_checks++; if ({q0, qn0, inv0} !== 3'b111) $display("FAIL ovr_inv_after_rst: got %b want 111", {q0, qn0, inv0}); else n_pass++;
        S = 1'b1; R = 1'b1;
        tick(2);
    endtask

    task automatic test_sync_latency();
        rst = 1'b1; S = 1'b1; R = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        n_checks++; if ({q2, qn2, inv2} !== 3'b010) $display("FAIL sync_idle: got %b want 010", {q2, qn2, inv2}); else n_pass++;
        S = 1'b0;
        tick(1);
        n_checks++; if (q2 !== 1'b0) $display("FAIL sync_edge1: got %b want 0", q2); else n_pass++;
        S = 1'b1;
        tick(1);
        n_checks++; if (q2 !== 1'b0) $display("FAIL sync_edge2: got %b want 0", q2); else n_pass++;
        tick(1);
        n_checks++; if ({q2, qn2, inv2} !== 3'b100) $display("FAIL sync_edge3: got %b want 100", {q2, qn2, inv2}); else n_pass++;
        tick(5);
        n_checks++; if ({q2, qn2, inv2} !== 3'b100) $display("FAIL sync_retain: got %b want 100", {q2, qn2, inv2}); else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0] m0, m2, p_s, p_r;
        rst = 1'b1; S = 1'b1; R = 1'b1;
        tick(2);
        m0 = 2'd0; m2 = 2'd0; p_s = 2'b11; p_r = 2'b11;
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 15) == 0);
            S   = 1'($urandom_range(0, 1));
            R   = 1'($urandom_range(0, 1));
            if (rst) begin
                m0 = 2'd0;
                m2 = 2'd0;
                p_s = 2'b11;
                p_r = 2'b11;
            end else begin
                m0 = model_next(m0, S, R, 1'b0);
                m2 = model_next(m2, p_s[1], p_r[1], 1'b1);
                p_s = {p_s[0], S};
                p_r = {p_r[0], R};
            end
            tick(1);
            n_checks++;
            if ({q0, qn0, inv0} !== model_out(m0))
                $display("FAIL rand_sync0 cyc %0d: got %b want %b", i, {q0, qn0, inv0}, model_out(m0));
            else n_pass++;
            n_checks++;
            if ({q2, qn2, inv2} !== model_out(m2))
                $display("FAIL rand_sync2 cyc %0d: got %b want %b", i, {q2, qn2, inv2}, model_out(m2));
            else n_pass++;
        end
        rst = 1'b0; S = 1'b1; R = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; S = 1'b1; R = 1'b1;
        test_reset();
        test_set();
        test_reset_req();
        test_invalid();
        test_rst_override();
        test_sync_latency();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
